// File: rtl/axi_part_mapper_if.sv
// AXI4 bundle used on both sides of the partition mapper (64-bit data, user = partition id).
interface axi_part_mapper_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 1,
    parameter int USER_W = 2
) ();
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [USER_W-1:0] awuser;
    logic              awvalid;
    logic              awready;

    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [USER_W-1:0] aruser;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awid, awlen, awsize, awburst, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output araddr, arid, arlen, arsize, arburst, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awid, awlen, awsize, awburst, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  araddr, arid, arlen, arsize, arburst, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_part_mapper.sv
// AXI partition mapper: AW/AR one-entry slices that remap addresses into a partition
// window, zero-latency W/B/R pass-through, and an enable FSM that drains all
// outstanding transactions before the mapping mode is switched.
//
// state    | meaning
// ST_IDLE  | mapping mode stable, traffic flows
// ST_DRAIN | mode change requested, new AW/AR blocked until counters reach 0
// ST_APPLY | load requested mode into part_en_active, then back to idle
module axi_part_mapper #(
    parameter int                ADDR_W   = 32,
    parameter int                ID_W     = 1,
    parameter int                NPART    = 4,
    parameter int                WIN_LOG2 = 28,
    parameter logic [ADDR_W-1:0] OUT_BASE = '0,
    parameter int                MAX_OUT  = 4
) (
    input  logic                coreclk,
    input  logic                corersts,
    input  logic                mem_part_en,
    output logic                part_en_active,
    output logic                drain_busy,
    axi_part_mapper_if.slave    s_axi,
    axi_part_mapper_if.master   m_axi
);
    localparam int PART_W = $clog2(NPART);
    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_OUT);
    localparam logic [ADDR_W-1:0] LOW_MASK = (ADDR_W'(1) << WIN_LOG2) - ADDR_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_APPLY} state_t;

    state_t            state_q, state_d;
    logic              active_q, active_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d, rcnt_q, rcnt_d;

    logic              aw_valid_q, aw_valid_d;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [ID_W-1:0]   aw_id_q;
    logic [7:0]        aw_len_q;
    logic [2:0]        aw_size_q;
    logic [1:0]        aw_burst_q;

    logic              ar_valid_q, ar_valid_d;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [ID_W-1:0]   ar_id_q;
    logic [7:0]        ar_len_q;
    logic [2:0]        ar_size_q;
    logic [1:0]        ar_burst_q;

    logic aw_stall, ar_stall;
    logic s_aw_fire, m_aw_fire, s_ar_fire, m_ar_fire, b_fire, r_done;

    function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic [PART_W-1:0] part,
                                                   input logic en);
        if (en)
            return OUT_BASE + (ADDR_W'(part) << WIN_LOG2) + (addr & LOW_MASK);
        return addr;
    endfunction

    // Saturating so a stray response at 0 (or an extra request at max) cannot wrap.
    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                   input logic inc, input logic dec);
        if (inc && !dec && cnt != CNT_MAX)
            return cnt + CNT_W'(1);
        if (dec && !inc && cnt != '0)
            return cnt - CNT_W'(1);
        return cnt;
    endfunction

    assign part_en_active = active_q;
    assign drain_busy     = (state_q != ST_IDLE);
    assign aw_stall       = (wcnt_q == CNT_MAX) || drain_busy;
    assign ar_stall       = (rcnt_q == CNT_MAX) || drain_busy;

    assign s_axi.awready = (!aw_valid_q || m_axi.awready) && !aw_stall;
    assign s_axi.arready = (!ar_valid_q || m_axi.arready) && !ar_stall;
    assign s_aw_fire     = s_axi.awvalid && s_axi.awready;
    assign m_aw_fire     = aw_valid_q && m_axi.awready;
    assign s_ar_fire     = s_axi.arvalid && s_axi.arready;
    assign m_ar_fire     = ar_valid_q && m_axi.arready;
    assign b_fire        = s_axi.bvalid && s_axi.bready;
    assign r_done        = s_axi.rvalid && s_axi.rready && s_axi.rlast;

    assign m_axi.awvalid = aw_valid_q;
    assign m_axi.awaddr  = aw_addr_q;
    assign m_axi.awid    = aw_id_q;
    assign m_axi.awlen   = aw_len_q;
    assign m_axi.awsize  = aw_size_q;
    assign m_axi.awburst = aw_burst_q;
    assign m_axi.awuser  = '0;
    assign m_axi.arvalid = ar_valid_q;
    assign m_axi.araddr  = ar_addr_q;
    assign m_axi.arid    = ar_id_q;
    assign m_axi.arlen   = ar_len_q;
    assign m_axi.arsize  = ar_size_q;
    assign m_axi.arburst = ar_burst_q;
    assign m_axi.aruser  = '0;

    assign m_axi.wdata   = s_axi.wdata;
    assign m_axi.wstrb   = s_axi.wstrb;
    assign m_axi.wlast   = s_axi.wlast;
    assign m_axi.wvalid  = s_axi.wvalid;
    assign s_axi.wready  = m_axi.wready;
    assign s_axi.bid     = m_axi.bid;
    assign s_axi.bresp   = m_axi.bresp;
    assign s_axi.bvalid  = m_axi.bvalid;
    assign m_axi.bready  = s_axi.bready;
    assign s_axi.rid     = m_axi.rid;
    assign s_axi.rdata   = m_axi.rdata;
    assign s_axi.rresp   = m_axi.rresp;
    assign s_axi.rlast   = m_axi.rlast;
    assign s_axi.rvalid  = m_axi.rvalid;
    assign m_axi.rready  = s_axi.rready;

    // Slice occupancy and outstanding-transaction counters.
    always_comb begin
        aw_valid_d = aw_valid_q;
        ar_valid_d = ar_valid_q;
        if (s_aw_fire)      aw_valid_d = 1'b1;
        else if (m_aw_fire) aw_valid_d = 1'b0;
        if (s_ar_fire)      ar_valid_d = 1'b1;
        else if (m_ar_fire) ar_valid_d = 1'b0;
        wcnt_d = next_cnt(wcnt_q, s_aw_fire, b_fire);
        rcnt_d = next_cnt(rcnt_q, s_ar_fire, r_done);
    end

    // Enable FSM: block new requests, wait for zero outstanding, then switch.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        case (state_q)
            ST_IDLE:  if (mem_part_en != active_q) state_d = ST_DRAIN;
            ST_DRAIN: if (wcnt_q == '0 && rcnt_q == '0) state_d = ST_APPLY;
            ST_APPLY: begin
                active_d = mem_part_en;
                state_d  = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge coreclk or posedge corersts) begin
        if (corersts) begin
            state_q    <= ST_IDLE;
            active_q   <= 1'b0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            aw_valid_q <= 1'b0;
            ar_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            aw_valid_q <= aw_valid_d;
            ar_valid_q <= ar_valid_d;
        end
    end

    // Slice payloads; the address is remapped on capture with the mode in force at accept.
    always_ff @(posedge coreclk or posedge corersts) begin
        if (corersts) begin
            aw_addr_q  <= '0;
            aw_id_q    <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            ar_addr_q  <= '0;
            ar_id_q    <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
        end else begin
            if (s_aw_fire) begin
                aw_addr_q  <= map_addr(s_axi.awaddr, s_axi.awuser, active_q);
                aw_id_q    <= s_axi.awid;
                aw_len_q   <= s_axi.awlen;
                aw_size_q  <= s_axi.awsize;
                aw_burst_q <= s_axi.awburst;
            end
            if (s_ar_fire) begin
                ar_addr_q  <= map_addr(s_axi.araddr, s_axi.aruser, active_q);
                ar_id_q    <= s_axi.arid;
                ar_len_q   <= s_axi.arlen;
                ar_size_q  <= s_axi.arsize;
                ar_burst_q <= s_axi.arburst;
            end
        end
    end
endmodule

// File: tb/tb_axi_part_mapper.sv
// Bench for axi_part_mapper: directed AW/AR traffic, expected slice outputs queued at
// issue time and checked by a monitor whenever the master side hands one off.
module tb_axi_part_mapper;
    logic clk = 1'b0;
    logic rst;
    logic mem_part_en;
    logic part_en_active;
    logic drain_busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [0:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ax_t;

    ax_t aw_q[$];
    ax_t ar_q[$];

    axi_part_mapper_if #(.ADDR_W(32), .ID_W(1), .USER_W(2)) s_if ();
    axi_part_mapper_if #(.ADDR_W(32), .ID_W(1), .USER_W(2)) m_if ();

    axi_part_mapper #(
        .ADDR_W(32), .ID_W(1), .NPART(4), .WIN_LOG2(28), .OUT_BASE(32'h0), .MAX_OUT(4)
    ) dut (
        .coreclk       (clk),
        .corersts      (rst),
        .mem_part_en   (mem_part_en),
        .part_en_active(part_en_active),
        .drain_busy    (drain_busy),
        .s_axi         (s_if),
        .m_axi         (m_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare each address handed off on the master side.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_if.awvalid && m_if.awready) begin
                if (aw_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL aw_unexpected: got addr 0x%0h, expected none", m_if.awaddr);
                end else begin
                    ax_t e;
                    e = aw_q.pop_front();
                    chk("m_awaddr", 64'(m_if.awaddr), 64'(e.addr));
                    chk("m_aw_attr", 64'({m_if.awid, m_if.awlen, m_if.awsize, m_if.awburst}),
                        64'({e.id, e.len, e.size, e.burst}));
                end
            end
            if (m_if.arvalid && m_if.arready) begin
                if (ar_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL ar_unexpected: got addr 0x%0h, expected none", m_if.araddr);
                end else begin
                    ax_t e;
                    e = ar_q.pop_front();
                    chk("m_araddr", 64'(m_if.araddr), 64'(e.addr));
                    chk("m_ar_attr", 64'({m_if.arid, m_if.arlen, m_if.arsize, m_if.arburst}),
                        64'({e.id, e.len, e.size, e.burst}));
                end
            end
        end
    end

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [1:0] user, input logic id,
                           input logic [7:0] len, input logic [31:0] exp_addr);
        int n;
        aw_q.push_back('{addr: exp_addr, id: id, len: len, size: 3'd3, burst: 2'b01});
        s_if.awaddr = addr; s_if.awuser = user; s_if.awid = id; s_if.awlen = len;
        s_if.awsize = 3'd3; s_if.awburst = 2'b01; s_if.awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_if.awready && n < 50) begin @(negedge clk); n++; end
        chk("s_aw_accept", 64'(s_if.awready), 64'd1);
        if (!s_if.awready) begin
            s_if.awvalid = 1'b0;
            void'(aw_q.pop_back());
            idle(1);
            return;
        end
        @(posedge clk); #1 s_if.awvalid = 1'b0;
        @(negedge clk);
        chk("m_awvalid_latency", 64'(m_if.awvalid), 64'd1);
        idle(1);
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [1:0] user, input logic id,
                           input logic [7:0] len, input logic [31:0] exp_addr);
        int n;
        ar_q.push_back('{addr: exp_addr, id: id, len: len, size: 3'd3, burst: 2'b01});
        s_if.araddr = addr; s_if.aruser = user; s_if.arid = id; s_if.arlen = len;
        s_if.arsize = 3'd3; s_if.arburst = 2'b01; s_if.arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_if.arready && n < 50) begin @(negedge clk); n++; end
        chk("s_ar_accept", 64'(s_if.arready), 64'd1);
        if (!s_if.arready) begin
            s_if.arvalid = 1'b0;
            void'(ar_q.pop_back());
            idle(1);
            return;
        end
        @(posedge clk); #1 s_if.arvalid = 1'b0;
        @(negedge clk);
        chk("m_arvalid_latency", 64'(m_if.arvalid), 64'd1);
        idle(1);
    endtask

    task automatic send_b(input logic id);
        m_if.bid = id; m_if.bresp = 2'b00; m_if.bvalid = 1'b1;
        @(negedge clk);
        chk("b_pass", 64'({s_if.bvalid, s_if.bid}), 64'({1'b1, id}));
        @(posedge clk); #1 m_if.bvalid = 1'b0;
    endtask

    task automatic send_r(input logic last, input logic [63:0] data);
        m_if.rid = 1'b0; m_if.rresp = 2'b00; m_if.rdata = data; m_if.rlast = last;
        m_if.rvalid = 1'b1;
        @(negedge clk);
        chk("r_pass", s_if.rdata, data);
        chk("r_last_pass", 64'({s_if.rvalid, s_if.rlast}), 64'({1'b1, last}));
        @(posedge clk); #1 m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    endtask

    task automatic wait_active(input logic v);
        int n;
        n = 0;
        while (part_en_active !== v && n < 50) begin idle(1); n++; end
        chk("part_en_active", 64'(part_en_active), 64'(v));
    endtask

    initial begin
        rst = 1'b1; mem_part_en = 1'b0;
        s_if.awaddr = '0; s_if.awuser = '0; s_if.awid = '0; s_if.awlen = '0;
        s_if.awsize = '0; s_if.awburst = '0; s_if.awvalid = 1'b0;
        s_if.araddr = '0; s_if.aruser = '0; s_if.arid = '0; s_if.arlen = '0;
        s_if.arsize = '0; s_if.arburst = '0; s_if.arvalid = 1'b0;
        s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0;
        s_if.bready = 1'b1; s_if.rready = 1'b1;
        m_if.awready = 1'b1; m_if.arready = 1'b1; m_if.wready = 1'b1;
        m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = 1'b0;
        m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 1'b0; m_if.rvalid = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_m_awvalid", 64'(m_if.awvalid), 64'd0);
        chk("rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
        chk("rst_active", 64'(part_en_active), 64'd0);
        chk("rst_drain_busy", 64'(drain_busy), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        idle(1);

        // Mapping disabled: AR passes unchanged; W passes through
        send_ar(32'h8000_0040, 2'd1, 1'b0, 8'd0, 32'h8000_0040);
        send_r(1'b1, 64'h0123_4567_89AB_CDEF);
        s_if.wdata = 64'hDEAD_BEEF_0000_1111; s_if.wvalid = 1'b1; s_if.wlast = 1'b1;
        #1 chk("w_pass", m_if.wdata, 64'hDEAD_BEEF_0000_1111);
        chk("w_ctl_pass", 64'({m_if.wvalid, m_if.wlast}), 64'h3);
        s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
        idle(1);

        // Enable mapping with nothing outstanding, then mapped writes
        mem_part_en = 1'b1;
        wait_active(1'b1);
        chk("drain_done", 64'(drain_busy), 64'd0);
        send_aw(32'h8123_4560, 2'd2, 1'b1, 8'd7, 32'h2123_4560);
        send_b(1'b1);
        send_aw(32'h0000_0010, 2'd3, 1'b0, 8'd3, 32'h3000_0010);
        send_b(1'b0);

        // Disable again, then request enable with three writes outstanding
        mem_part_en = 1'b0;
        wait_active(1'b0);
        for (int i = 0; i < 3; i++)
            send_aw(32'h1000_0000 + 32'(i * 64), 2'd1, 1'b0, 8'd1, 32'h1000_0000 + 32'(i * 64));
        mem_part_en = 1'b1;
        idle(2);
        chk("drain_busy_set", 64'(drain_busy), 64'd1);
        chk("drain_awready", 64'(s_if.awready), 64'd0);
        send_b(1'b0);
        send_b(1'b0);
        chk("drain_hold_awready", 64'(s_if.awready), 64'd0);
        chk("drain_hold_active", 64'(part_en_active), 64'd0);
        send_b(1'b0);
        wait_active(1'b1);
        send_aw(32'h8123_4560, 2'd1, 1'b0, 8'd0, 32'h1123_4560);
        send_b(1'b0);

        // Four reads outstanding block the fifth until a burst completes
        for (int i = 0; i < 4; i++)
            send_ar(32'h0000_1000 + 32'(i * 8), 2'd2, 1'b1, 8'd0, 32'h2000_1000 + 32'(i * 8));
        ar_q.push_back('{addr: 32'h3000_0500, id: 1'b0, len: 8'd0, size: 3'd3, burst: 2'b01});
        s_if.araddr = 32'hF000_0500; s_if.aruser = 2'd3; s_if.arid = 1'b0; s_if.arlen = 8'd0;
        s_if.arsize = 3'd3; s_if.arburst = 2'b01; s_if.arvalid = 1'b1;
        idle(1);
        chk("ar_full_stall", 64'(s_if.arready), 64'd0);
        send_r(1'b0, 64'h1);
        chk("ar_stall_nonlast", 64'(s_if.arready), 64'd0);
        send_r(1'b1, 64'h2);
        chk("ar_reopen", 64'(s_if.arready), 64'd1);
        @(posedge clk); #1 s_if.arvalid = 1'b0;
        for (int i = 0; i < 4; i++) send_r(1'b1, 64'(i));

        // Simultaneous AW accept and B at wcnt=2 leaves the count at 2
        send_aw(32'h0000_0200, 2'd0, 1'b0, 8'd0, 32'h0000_0200);
        send_aw(32'h0000_0204, 2'd0, 1'b0, 8'd0, 32'h0000_0204);
        aw_q.push_back('{addr: 32'h1000_0300, id: 1'b1, len: 8'd2, size: 3'd3, burst: 2'b01});
        s_if.awaddr = 32'h0000_0300; s_if.awuser = 2'd1; s_if.awid = 1'b1; s_if.awlen = 8'd2;
        s_if.awsize = 3'd3; s_if.awburst = 2'b01; s_if.awvalid = 1'b1; m_if.bvalid = 1'b1;
        @(negedge clk);
        chk("simul_awready", 64'(s_if.awready), 64'd1);
        @(posedge clk); #1 s_if.awvalid = 1'b0; m_if.bvalid = 1'b0;
        send_aw(32'h0000_0208, 2'd0, 1'b0, 8'd0, 32'h0000_0208);
        send_aw(32'h0000_020C, 2'd0, 1'b0, 8'd0, 32'h0000_020C);
        s_if.awaddr = 32'h0000_0400; s_if.awvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("aw_full_stall", 64'(s_if.awready), 64'd0);
        end
        @(posedge clk); #1 s_if.awvalid = 1'b0;
        for (int i = 0; i < 4; i++) send_b(1'b0);

        // Slice contents held while m_awready is low
        m_if.awready = 1'b0;
        send_aw(32'h0000_0400, 2'd2, 1'b1, 8'd15, 32'h2000_0400);
        s_if.awaddr = 32'hFFFF_FFF0; s_if.awuser = 2'd3; s_if.awid = 1'b0; s_if.awlen = 8'd9;
        s_if.awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(m_if.awvalid), 64'd1);
            chk("hold_addr", 64'(m_if.awaddr), 64'h2000_0400);
            chk("hold_len", 64'(m_if.awlen), 64'd15);
            chk("hold_sready", 64'(s_if.awready), 64'd0);
        end
        @(posedge clk); #1 s_if.awvalid = 1'b0; m_if.awready = 1'b1;
        idle(1);
        send_b(1'b1);

        // Asynchronous reset with two reads outstanding, one still in the slice
        send_ar(32'h0000_0010, 2'd0, 1'b0, 8'd0, 32'h0000_0010);
        m_if.arready = 1'b0;
        send_ar(32'h0000_0020, 2'd0, 1'b0, 8'd0, 32'h0000_0020);
        chk("pre_rst_arvalid", 64'(m_if.arvalid), 64'd1);
        #2 rst = 1'b1;
        #1 chk("async_rst_arvalid", 64'(m_if.arvalid), 64'd0);
        chk("async_rst_active", 64'(part_en_active), 64'd0);
        chk("async_rst_busy", 64'(drain_busy), 64'd0);
        ar_q.delete();
        m_if.arready = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        idle(1);
        chk("post_rst_first_edge", 64'(drain_busy), 64'd1);
        wait_active(1'b1);
        for (int i = 0; i < 4; i++)
            send_ar(32'hC000_0100 + 32'(i * 4), 2'd0, 1'b0, 8'd0, 32'h0000_0100 + 32'(i * 4));
        s_if.araddr = 32'h0000_0800; s_if.arvalid = 1'b1;
        @(negedge clk);
        chk("post_rst_rcnt_full", 64'(s_if.arready), 64'd0);
        @(posedge clk); #1 s_if.arvalid = 1'b0;
        idle(2);

        chk("aw_q_empty", 64'(aw_q.size()), 64'd0);
        chk("ar_q_empty", 64'(ar_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_part_mapper.md
AXI_PART_MAPPER -- requirements
Module: axi_part_mapper

Interface
REQ-001 Parameters, each SHALL be: name, default, meaning.
- ADDR_W, 32, AXI address width.
- ID_W, 1, AXI ID width.
- NPART, 4, partition count; power of two, >=2.
- WIN_LOG2, 28, log2 of partition window size in bytes.
- OUT_BASE, 0, base of the mapped output region.
- MAX_OUT, 4, max outstanding transactions per direction.
REQ-002 Ports SHALL be: name, direction, width, meaning.
- coreclk, in, 1, sole clock.
- corersts, in, 1, reset; asynchronous, active-high.
- mem_part_en, in, 1, requested partition-mapping enable.
- part_en_active, out, 1, enable currently applied.
- drain_busy, out, 1, enable change pending, draining.
- s_axi_aw*/ar*, in/out, AXI4 address channels: addr ADDR_W, id ID_W, len 8, size 3, burst 2, user PART_W=log2(NPART) (dsid), valid, ready.
- m_axi_aw*/ar*, out/in, same fields minus user.
- s_axi_w*/b*/r* <-> m_axi_w*/b*/r*, AXI4 W/B/R channels, 64-bit data.

Function
REQ-003 AW and AR SHALL each pass through a one-entry register slice; m_valid rises the cycle after s accept.
REQ-004 Slice s_ready SHALL be (!slice_valid || m_ready) && !stall.
- stall = count==MAX_OUT || drain_busy.
REQ-005 W, B and R SHALL be combinational pass-through with zero latency.
REQ-006 When part_en_active=1, captured address SHALL be OUT_BASE + (user << WIN_LOG2) + addr[WIN_LOG2-1:0], truncated to ADDR_W.
REQ-007 When part_en_active=0, address SHALL pass unchanged.
REQ-008 id, len, size, burst SHALL be copied unchanged.
REQ-009 Mapping SHALL use part_en_active at s-side accept; the slice holds the mapped address.
REQ-010 Write counter wcnt SHALL:
- +1 on s_aw fire.
- -1 on s_b fire.
- be unchanged on simultaneous fire.
REQ-011 Read counter rcnt SHALL:
- +1 on s_ar fire.
- -1 on s_r fire with rlast.
- be unchanged on simultaneous fire.
REQ-012 Counters SHALL be $clog2(MAX_OUT+1) wide and never wrap.
- Decrement at 0 (protocol violation) holds 0.
REQ-013 Enable FSM states SHALL be IDLE, DRAIN, APPLY.
- IDLE -> DRAIN when mem_part_en != part_en_active.
- DRAIN -> APPLY when wcnt==0 && rcnt==0.
- APPLY: part_en_active <= mem_part_en for one cycle, then -> IDLE.
REQ-014 drain_busy SHALL be 1 in DRAIN and APPLY.
- s_awready and s_arready SHALL be 0 in those states.
REQ-015 If mem_part_en reverts during DRAIN, the FSM SHALL still complete DRAIN/APPLY.
- APPLY samples the current mem_part_en, so a revert yields no net change.
REQ-016 Slice entries SHALL NOT be discarded or modified while m_ready is low.

Reset
REQ-017 On corersts, all of the following SHALL hold:
- slices empty; m_awvalid=m_arvalid=0.
- wcnt=rcnt=0.
- FSM=IDLE; part_en_active=0; drain_busy=0.
REQ-018 Reset mid-transaction SHALL abandon outstanding bursts without emitting responses.
REQ-019 After reset release, FSM SHALL evaluate mem_part_en on the first clock edge.

Verification
REQ-020 en=1, AW addr 0x8123_4560, user=2 -> m_awaddr 0x2123_4560 one cycle after accept; id/len unchanged.
REQ-021 en=0 (active=0), AR addr 0x8000_0040 -> m_araddr 0x8000_0040.
REQ-022 Three writes outstanding, mem_part_en 0->1:
- drain_busy=1; s_awready=0 until the third B.
- part_en_active=1 one cycle after counters reach 0 (APPLY).
- next AW is mapped.
REQ-023 MAX_OUT=4, four ARs with no R -> fifth AR stalled.
- Completing one burst (rlast) reopens s_arready the next cycle.
REQ-024 s_aw fire and s_b fire in the same cycle at wcnt=2 -> wcnt stays 2.
- m_awready held low 5 cycles -> slice contents stable.
REQ-025 corersts asserted with 2 ARs outstanding and m_arvalid=1:
- m_arvalid=0 and rcnt=0 immediately (asynchronous).
- part_en_active=0.
